// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct codes,
// sequencer states and operation decode helpers.
package muldiv_pkg;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_t;

    function automatic logic is_arith(input logic [5:0] funct);
        return (funct == FN_MULT) || (funct == FN_MULTU) ||
               (funct == FN_DIV)  || (funct == FN_DIVU);
    endfunction

    function automatic op_t decode_op(input logic [5:0] funct);
        op_t op;
        case (funct)
            FN_MULT: op = OP_MULT;
            FN_DIV:  op = OP_DIV;
            FN_DIVU: op = OP_DIVU;
            default: op = OP_MULTU;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 iteration datapath: shift-add multiply or restoring divide on
// unsigned magnitudes, one step per enabled cycle.
module muldiv_datapath #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [DATA_W-1:0] a_mag,
    input  logic [DATA_W-1:0] b_mag,
    output logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] low
);

    logic [DATA_W-1:0] operand;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;
    logic              ge;

    // Divide: a set top bit of the shifted remainder means it already exceeds
    // any DATA_W-bit divisor, so the DATA_W+1-bit difference's top bit is only
    // a borrow indicator when that bit is clear.
    always_comb begin
        sum     = {1'b0, acc} + (low[0] ? {1'b0, operand} : '0);
        shifted = {acc, low[DATA_W-1]};
        diff    = shifted - {1'b0, operand};
        ge      = shifted[DATA_W] | ~diff[DATA_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            low     <= '0;
            operand <= '0;
        end else if (load) begin
            acc     <= '0;
            low     <= a_mag;
            operand <= b_mag;
        end else if (step) begin
            if (is_div) begin
                acc <= ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
                low <= {low[DATA_W-2:0], ge};
            end else begin
                acc <= sum[DATA_W:1];
                low <= {sum[0], low[DATA_W-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// MIPS EX-stage multiply/divide sequencer: owns HI/LO, runs the iterative
// datapath for DATA_W cycles and applies sign fix-up before writing results.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [5:0]        Funct,
    input  logic [DATA_W-1:0] OperandA,
    input  logic [DATA_W-1:0] OperandB,
    input  logic              Flush,
    output logic              Ready,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO
);

    localparam int unsigned CW = $clog2(DATA_W + 1);

    state_t              state;
    state_t              next_state;
    op_t                 op;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [CW-1:0]       count;
    logic                res_neg;
    logic                rem_neg;
    logic                load;
    logic                step;
    logic                write_result;
    logic                is_signed;
    logic                is_div;
    logic                neg_a;
    logic                neg_b;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   low;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   fix_hi;
    logic [DATA_W-1:0]   fix_lo;

    assign Ready = (state == S_IDLE);
    assign Busy  = (state != S_IDLE);
    assign Done  = (state == S_DONE);

    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign is_div    = (op == OP_DIV)  || (op == OP_DIVU);
    assign neg_a     = is_signed & op_a[DATA_W-1];
    assign neg_b     = is_signed & op_b[DATA_W-1];
    assign a_mag     = neg_a ? -op_a : op_a;
    assign b_mag     = neg_b ? -op_b : op_b;

    muldiv_datapath #(
        .DATA_W(DATA_W)
    ) u_datapath (
        .clk   (Clk),
        .rst_n (Reset),
        .load  (load),
        .step  (step),
        .is_div(is_div),
        .a_mag (a_mag),
        .b_mag (b_mag),
        .acc   (acc),
        .low   (low)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        load         = 1'b0;
        step         = 1'b0;
        write_result = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start && !Flush && is_arith(Funct)) next_state = S_PREP;
            end
            S_PREP: begin
                load       = 1'b1;
                next_state = Flush ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                step = 1'b1;
                if (Flush)                  next_state = S_IDLE;
                else if (count == CW'(1))   next_state = S_FIX;
            end
            S_FIX: begin
                write_result = !Flush;
                next_state   = Flush ? S_IDLE : S_DONE;
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Divide-by-zero bypasses sign fix-up so HI/LO come out as A / all-ones
    // regardless of operand signs.
    always_comb begin
        prod   = {acc, low};
        fix_hi = '0;
        fix_lo = '0;
        if (is_div) begin
            if (op_b == '0) begin
                fix_hi = op_a;
                fix_lo = '1;
            end else begin
                fix_hi = rem_neg ? -acc : acc;
                fix_lo = res_neg ? -low : low;
            end
        end else begin
            if (res_neg) prod = -prod;
            fix_hi = prod[2*DATA_W-1:DATA_W];
            fix_lo = prod[DATA_W-1:0];
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            op      <= OP_MULTU;
            op_a    <= '0;
            op_b    <= '0;
            count   <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            if (state == S_IDLE && Start && !Flush) begin
                if (is_arith(Funct)) begin
                    op   <= decode_op(Funct);
                    op_a <= OperandA;
                    op_b <= OperandB;
                end else if (Funct == FN_MTHI) begin
                    HI <= OperandA;
                end else if (Funct == FN_MTLO) begin
                    LO <= OperandA;
                end
            end
            if (load) begin
                count   <= CW'(DATA_W);
                res_neg <= neg_a ^ neg_b;
                rem_neg <= neg_a;
            end else if (step) begin
                count <= count - CW'(1);
            end
            if (write_result) begin
                HI <= fix_hi;
                LO <= fix_lo;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed plus randomized checks of muldiv_sequencer against a plain
// arithmetic HI/LO reference model.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [5:0]  Funct;
    logic [31:0] OperandA;
    logic [31:0] OperandB;
    logic        Flush;
    logic        Ready;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    muldiv_sequencer #(
        .DATA_W(32)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .Funct   (Funct),
        .OperandA(OperandA),
        .OperandB(OperandB),
        .Flush   (Flush),
        .Ready   (Ready),
        .Busy    (Busy),
        .Done    (Done),
        .HI      (HI),
        .LO      (LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        longint          q;
        longint          r;
        longint unsigned p;
        case (f)
            FN_MULT:  p = longint'(sa * sb);
            FN_MULTU: p = ua * ub;
            FN_DIV: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else            p = {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
        return p;
    endfunction

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] expv, input int inject_at);
        int n;
        int gaps;
        @(negedge Clk);
        Start = 1'b1; Funct = f; OperandA = a; OperandB = b;
        @(negedge Clk);
        Start = 1'b0; OperandA = $urandom; OperandB = $urandom;
        n = 1; gaps = 0;
        while (!Done && n < 60) begin
            if (!Busy) gaps++;
            Start = (n == inject_at);
            if (n == inject_at) begin
                Funct = FN_DIVU; OperandA = 32'd1000; OperandB = 32'd3;
            end
            @(negedge Clk);
            n++;
        end
        Start = 1'b0;
        check({tag, "/latency"}, 64'(n), 64'd35);
        check({tag, "/busy_gaps"}, 64'(gaps), 64'd0);
        check({tag, "/busy_at_done"}, 64'(Busy), 64'd1);
        check({tag, "/hi"}, 64'(HI), 64'(expv[63:32]));
        check({tag, "/lo"}, 64'(LO), 64'(expv[31:0]));
        exp_hi = expv[63:32];
        exp_lo = expv[31:0];
        @(negedge Clk);
        check({tag, "/ready_after"}, 64'({Ready, Done}), 64'b10);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 50));
            2:       return corners[$urandom_range(0, 4)];
            default: return -32'($urandom_range(1, 50));
        endcase
    endfunction

    initial begin
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  fns [4] = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
        int          n;
        int          dones;

        Reset = 1'b0; Start = 1'b0; Flush = 1'b0;
        Funct = '0; OperandA = '0; OperandB = '0;
        #3;
        check("reset/flags", 64'({Ready, Busy, Done}), 64'b100);
        check("reset/hilo", {HI, LO}, 64'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;

        run_op("multu_max", FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFFFFFE_00000001, -1);
        run_op("mult_neg", FN_MULT, -32'd3, 32'd7, 64'hFFFFFFFF_FFFFFFEB, -1);
        run_op("mult_min", FN_MULT, 32'h8000_0000, 32'h8000_0000, 64'h40000000_00000000, -1);
        run_op("div_neg", FN_DIV, -32'd7, 32'd2, 64'hFFFFFFFF_FFFFFFFD, -1);
        run_op("divu_zero", FN_DIVU, 32'd7, 32'd0, 64'h00000007_FFFFFFFF, -1);
        run_op("div_ovf", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, -1);
        run_op("div_zero_s", FN_DIV, -32'd9, 32'd0, {-32'd9, 32'hFFFF_FFFF}, -1);

        // MTHI then MTLO back to back.
        @(negedge Clk);
        Start = 1'b1; Funct = FN_MTHI; OperandA = 32'h1234;
        @(negedge Clk);
        Funct = FN_MTLO; OperandA = 32'hABCD;
        check("mthi/hi", 64'(HI), 64'h1234);
        check("mthi/flags", 64'({Busy, Done}), 64'b00);
        @(negedge Clk);
        Start = 1'b0;
        check("mtlo/hilo", {HI, LO}, {32'h1234, 32'hABCD});
        check("mtlo/flags", 64'({Busy, Done}), 64'b00);
        exp_hi = 32'h1234; exp_lo = 32'hABCD;

        // Start with a non-muldiv funct and Start together with Flush are ignored.
        @(negedge Clk);
        Start = 1'b1; Funct = 6'b100000; OperandA = 32'hDEAD;
        @(negedge Clk);
        Funct = FN_MTHI; Flush = 1'b1;
        @(negedge Clk);
        Start = 1'b0; Flush = 1'b0;
        check("ignored/hilo", {HI, LO}, {exp_hi, exp_lo});
        check("ignored/ready", 64'(Ready), 64'd1);

        run_op("inject", FN_MULTU, 32'd123456, 32'd654321,
               64'(64'd123456 * 64'd654321), 5);

        // Flush at T0+10.
        @(negedge Clk);
        Start = 1'b1; Funct = FN_DIV; OperandA = 32'd999; OperandB = 32'd4;
        @(negedge Clk);
        Start = 1'b0;
        n = 1;
        while (n < 10) begin @(negedge Clk); n++; end
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        check("flush/ready", 64'(Ready), 64'd1);
        check("flush/hilo", {HI, LO}, {exp_hi, exp_lo});
        dones = 0;
        repeat (40) begin @(negedge Clk); if (Done) dones++; end
        check("flush/no_done", 64'(dones), 64'd0);
        check("flush/hilo_late", {HI, LO}, {exp_hi, exp_lo});

        // Asynchronous reset mid-divide.
        @(negedge Clk);
        Start = 1'b1; Funct = FN_DIV; OperandA = 32'd100; OperandB = 32'd7;
        @(negedge Clk);
        Start = 1'b0;
        n = 1;
        while (n < 20) begin @(negedge Clk); n++; end
        #2 Reset = 1'b0;
        #1;
        check("areset/hilo", {HI, LO}, 64'd0);
        check("areset/flags", 64'({Ready, Busy, Done}), 64'b100);
        @(negedge Clk);
        Reset = 1'b1;
        exp_hi = '0; exp_lo = '0;
        run_op("post_reset", FN_MULTU, 32'd5, 32'd6, 64'h00000000_0000001E, -1);

        for (int i = 0; i < 40; i++) begin
            f = fns[$urandom_range(0, 3)];
            a = pick_operand();
            b = pick_operand();
            run_op("rand", f, a, b, model(f, a, b), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
